// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: sequences the MEM stage of a 5-stage MIPS pipeline against
// a variable-latency data memory using a req/ack handshake.
//   Pipeline side : m_valid, m_load, m_store, m_addr, m_wdata (in)
//                   stall, wb_en, wb_bubble, mdo (out)
//   Memory side   : mem_req, mem_we, mem_addr, mem_wdata (out)
//                   mem_ack, mem_rdata (in)
//   Status        : err_misalign, err_timeout (sticky out), err_clr (in)
// FSM: IDLE -> ACCESS -> DONE | FAULT -> IDLE.
module mem_stage_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic              m_load,
  input  logic              m_store,
  input  logic [DATA_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic              wb_en,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] mdo,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;

  // Request latched at issue; held stable for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  state_t           state, state_nxt;
  mreq_t            req_q;
  logic [CNT_W-1:0] cnt;

  logic mem_op, aligned, issue, timeout_hit, set_mis, set_to;

  assign mem_op      = m_valid & (m_load | m_store);
  assign aligned     = (m_addr[1:0] == 2'b00);
  assign issue       = (state == IDLE) & mem_op & aligned;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign set_mis     = (state == IDLE) & mem_op & ~aligned;
  assign set_to      = (state == ACCESS) & ~mem_ack & timeout_hit;

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (issue) state_nxt = ACCESS;
      ACCESS: if (mem_ack)          state_nxt = DONE;
              else if (timeout_hit) state_nxt = FAULT;
      DONE:   state_nxt = IDLE;
      FAULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline control outputs. MEM/WB always loads; a held instruction is
  // expressed as a bubble rather than a frozen register.
  always_comb begin
    stall     = 1'b0;
    wb_en     = 1'b1;
    wb_bubble = 1'b0;
    case (state)
      IDLE: begin
        stall     = issue;
        wb_bubble = mem_op;   // misaligned ops are squashed without a stall
      end
      ACCESS: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
      end
      DONE:  ;
      FAULT: wb_bubble = 1'b1;
      default: ;
    endcase
  end

  // Request/datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_req <= 1'b0;
      req_q   <= '0;
      cnt     <= '0;
      mdo     <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          // load+store together is a load
          req_q   <= '{we: m_store & ~m_load, addr: m_addr, wdata: m_wdata};
          mem_req <= 1'b1;
          cnt     <= '0;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!req_q.we) mdo <= mem_rdata;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky errors; a new set wins over a same-cycle clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (set_mis)      err_misalign <= 1'b1;
      else if (err_clr) err_misalign <= 1'b0;
      if (set_to)       err_timeout  <= 1'b1;
      else if (err_clr) err_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled 1 unit later, well before the next edge.
module tb_mem_stage_ctrl;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          resetn;
  logic          m_valid, m_load, m_store;
  logic [DW-1:0] m_addr, m_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          err_clr;
  logic          mem_req, mem_we, stall, wb_en, wb_bubble;
  logic [DW-1:0] mem_addr, mem_wdata, mdo;
  logic          err_misalign, err_timeout;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(15), .CNT_W(4)) dut (
    .clock(clock), .resetn(resetn),
    .m_valid(m_valid), .m_load(m_load), .m_store(m_store),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err_clr(err_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall(stall), .wb_en(wb_en), .wb_bubble(wb_bubble), .mdo(mdo),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic idle_in();
    m_valid = 0; m_load = 0; m_store = 0; mem_ack = 0; err_clr = 0;
    m_addr = '0; m_wdata = '0; mem_rdata = 32'hBAD0_0000;
  endtask

  // One aligned memory instruction: presented in IDLE, ack after 'waits'
  // ACCESS cycles, then DONE is checked. Returns at the start of an IDLE cycle.
  task automatic do_mem(input string tag, input bit ld, input bit st,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int waits,
                        input int exp_stall, input logic [DW-1:0] exp_mdo);
    int  stalls = 0;
    bit  bus_ok = 1;
    m_valid = 1; m_load = ld; m_store = st; m_addr = addr; m_wdata = wdata; mem_ack = 0;
    #1 if (stall) stalls++;
    chk({tag, "_noreq_idle"}, {31'b0, mem_req}, 0);
    cyc();
    // scramble the pipeline inputs to prove the request is latched
    m_addr = ~addr; m_wdata = ~wdata;
    for (int i = 0; i <= waits; i++) begin
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rdata : 32'hBAD0_0000 + i;
      #1;
      if (stall) stalls++;
      if (!(mem_req === 1'b1 && mem_we === (st & ~ld) && mem_addr === addr &&
            mem_wdata === wdata && wb_bubble === 1'b1)) bus_ok = 0;
      cyc();
    end
    mem_ack = 0; mem_rdata = 32'hBAD0_0000;
    #1;
    chk({tag, "_bus"},      {31'b0, bus_ok}, 1);
    chk({tag, "_stalls"},   stalls, exp_stall);
    chk({tag, "_done_stall"}, {31'b0, stall}, 0);
    chk({tag, "_done_bub"}, {31'b0, wb_bubble}, 0);
    chk({tag, "_done_req"}, {31'b0, mem_req}, 0);
    chk({tag, "_mdo"},      mdo, exp_mdo);
    m_valid = 0; m_load = 0; m_store = 0;
    cyc();
  endtask

  initial begin
    int n;
    idle_in();
    resetn = 0;
    #1;
    chk("rst_req",   {31'b0, mem_req}, 0);
    chk("rst_wb_en", {31'b0, wb_en}, 1);
    cyc(); cyc();
    resetn = 1;
    cyc();

    // 1: reset while an access is outstanding
    m_valid = 1; m_load = 1; m_addr = 32'h200;
    cyc();
    #1 chk("t1_req_up", {31'b0, mem_req}, 1);
    chk("t1_addr", mem_addr, 32'h200);
    m_valid = 0; m_load = 0;
    #2 resetn = 0;
    #1;
    chk("t1_req", {31'b0, mem_req}, 0);
    chk("t1_addr0", mem_addr, 0);
    chk("t1_stall", {31'b0, stall}, 0);
    chk("t1_bub", {31'b0, wb_bubble}, 0);
    chk("t1_mdo", mdo, 0);
    chk("t1_errs", {30'b0, err_misalign, err_timeout}, 0);
    cyc();
    resetn = 1;
    cyc();
    #1 chk("t1_idle_req", {31'b0, mem_req}, 0);
    chk("t1_idle_stall", {31'b0, stall}, 0);
    cyc();

    // 2: lw with immediate ack
    do_mem("t2", 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 32'hDEADBEEF);

    // 3: sw with 3 wait cycles, mdo unchanged
    do_mem("t3", 0, 1, 32'h104, 32'h12345678, 32'h55555555, 3, 5, 32'hDEADBEEF);

    // 4: misaligned lw squashed, sticky until clear
    m_valid = 1; m_load = 1; m_addr = 32'h102;
    #1;
    chk("t4_stall", {31'b0, stall}, 0);
    chk("t4_bub",   {31'b0, wb_bubble}, 1);
    cyc();
    m_valid = 0; m_load = 0; m_addr = 0;
    #1;
    chk("t4_noreq", {31'b0, mem_req}, 0);
    chk("t4_err",   {31'b0, err_misalign}, 1);
    cyc(); cyc();
    #1 chk("t4_err_hold", {31'b0, err_misalign}, 1);
    err_clr = 1;
    cyc();
    err_clr = 0;
    #1 chk("t4_err_clr", {31'b0, err_misalign}, 0);
    // set beats a same-cycle clear
    m_valid = 1; m_store = 1; m_addr = 32'h101; err_clr = 1;
    cyc();
    m_valid = 0; m_store = 0; m_addr = 0; err_clr = 0;
    #1 chk("t4_set_prio", {31'b0, err_misalign}, 1);
    err_clr = 1; cyc(); err_clr = 0;

    // 5: timeout
    m_valid = 1; m_load = 1; m_addr = 32'h108;
    cyc();
    n = 0;
    #1;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      cyc();
      #1;
    end
    chk("t5_req_cycles", n, 15);
    chk("t5_fault_stall", {31'b0, stall}, 0);
    chk("t5_fault_bub",   {31'b0, wb_bubble}, 1);
    chk("t5_err",         {31'b0, err_timeout}, 1);
    m_valid = 0; m_load = 0;
    cyc();
    do_mem("t5b", 1, 0, 32'h10C, 32'h0, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D);
    chk("t5_err_hold", {31'b0, err_timeout}, 1);
    err_clr = 1; cyc(); err_clr = 0;
    #1 chk("t5_err_clr", {31'b0, err_timeout}, 0);

    // 6: lw, add with stray ack, lw
    do_mem("t6a", 1, 0, 32'h200, 32'h0, 32'h11112222, 1, 3, 32'h11112222);
    m_valid = 1; mem_ack = 1; mem_rdata = 32'hFFFF0000;
    #1;
    chk("t6_add_stall", {31'b0, stall}, 0);
    chk("t6_add_bub",   {31'b0, wb_bubble}, 0);
    cyc();
    m_valid = 0; mem_ack = 0;
    #1;
    chk("t6_stray_req", {31'b0, mem_req}, 0);
    chk("t6_stray_mdo", mdo, 32'h11112222);
    do_mem("t6b", 1, 0, 32'h204, 32'h0, 32'h33334444, 2, 4, 32'h33334444);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
